// File: rtl/counter_pkg.sv
// Shared constants and elaboration helpers for the modulo-N counter.
package counter_pkg;

  localparam logic COUNT_UP   = 1'b1;
  localparam logic COUNT_DOWN = 1'b0;

  // True when 2 <= modulus <= 2**width.
  function automatic bit modulus_fits(
    input int unsigned modulus,
    input int unsigned width
  );
    return (modulus >= 2) && ($clog2(modulus) <= width);
  endfunction

endpackage

// File: rtl/mod_n_next.sv
// Next count value and wrap flag for one step in the selected direction.
module mod_n_next
  import counter_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input  logic [WIDTH-1:0] q_i,
  input  logic             up_i,
  output logic [WIDTH-1:0] next_o,
  output logic             wrap_o
);

  // One extra bit keeps the range compares meaningful at full modulus.
  localparam logic [WIDTH:0] MAXX = (WIDTH+1)'(MODULUS - 1);
  localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);

  logic [WIDTH:0] qx;

  assign qx = {1'b0, q_i};

  always_comb begin
    next_o = q_i;
    wrap_o = 1'b0;
    if (up_i == COUNT_UP) begin
      if (qx >= MAXX) begin
        next_o = '0;
        wrap_o = 1'b1;
      end else begin
        next_o = q_i + 1'b1;
      end
    end else begin
      if (q_i == '0) begin
        next_o = MAX;
        wrap_o = 1'b1;
      end else if (qx > MAXX) begin
        next_o = MAX;
      end else begin
        next_o = q_i - 1'b1;
      end
    end
  end

endmodule

// File: rtl/mod_n_counter.sv
// Up/down modulo-N counter with clear, load, ENP/ENT enables,
// cascadable ripple carry and a registered wrap pulse.
module mod_n_counter
  import counter_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             SCLR_n,
  input  logic             LOAD_n,
  input  logic             UP,
  input  logic             ENP,
  input  logic             ENT,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             RCO,
  output logic             TC
);

  generate
    if (!modulus_fits(MODULUS, WIDTH)) begin : g_bad_modulus
      $error("mod_n_counter: MODULUS out of range for WIDTH");
    end
  endgenerate

  logic [WIDTH-1:0] q_q, q_d;
  logic             tc_q, tc_d;
  logic [WIDTH-1:0] step;
  logic             wrap;

  // The wrap flag of a step doubles as the terminal-count detect.
  mod_n_next #(
    .WIDTH  (WIDTH),
    .MODULUS(MODULUS)
  ) u_next (
    .q_i   (q_q),
    .up_i  (UP),
    .next_o(step),
    .wrap_o(wrap)
  );

  always_comb begin
    q_d  = q_q;
    tc_d = 1'b0;
    if (!SCLR_n) begin
      q_d = '0;
    end else if (!LOAD_n) begin
      q_d = D;
    end else if (ENP && ENT) begin
      q_d  = step;
      tc_d = wrap;
    end
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      q_q  <= '0;
      tc_q <= 1'b0;
    end else begin
      q_q  <= q_d;
      tc_q <= tc_d;
    end
  end

  assign Q   = q_q;
  assign TC  = tc_q;
  assign RCO = ENT & wrap;

endmodule
